// File: rtl/upzero_sched.sv
// Round-robin scheduler sharing one upzero predictor-update engine between the
// lower- and higher-subband ADPCM encoder paths, with a watchdog abort.
module upzero_sched #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        req_lo,
    input  logic [16:0] dlt_lo,
    input  logic        req_hi,
    input  logic [16:0] dlt_hi,
    output logic        ack_lo,
    output logic        ack_hi,
    output logic        err,
    output logic        busy,
    output logic        up_start,
    output logic [16:0] up_dlt,
    output logic        up_sel,
    input  logic        up_ready,
    input  logic        up_done,
    output logic        up_rst
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic             last_grant_r;
    logic             grant_s;
    logic             grant_band_s;
    logic             complete_s;

    logic             ack_lo_r;
    logic             ack_hi_r;
    logic             err_r;
    logic             busy_r;
    logic             up_start_r;
    logic [16:0]      up_dlt_r;
    logic             up_sel_r;
    logic             up_rst_r;

    // Arbitration and next-state decode
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        grant_band_s = 1'b0;
        // ap_done alone is not trusted: the engine also raises it while idle
        complete_s   = up_ready & up_done;
        case (state_r)
            ST_IDLE: begin
                if (req_lo && req_hi) begin
                    grant_s      = 1'b1;
                    grant_band_s = ~last_grant_r;
                end else if (req_lo) begin
                    grant_s      = 1'b1;
                    grant_band_s = 1'b0;
                end else if (req_hi) begin
                    grant_s      = 1'b1;
                    grant_band_s = 1'b1;
                end else begin
                    grant_s      = 1'b0;
                    grant_band_s = 1'b0;
                end
                if (grant_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (complete_s) begin
                    state_next_s = ST_DONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_ABORT;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE:  state_next_s = ST_IDLE;
            ST_ABORT: state_next_s = ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // State, watchdog counter and round-robin history
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            last_grant_r <= 1'b1;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                cnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_RUN) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else begin
                cnt_r <= cnt_r;
            end
            if ((state_r == ST_DONE) || (state_r == ST_ABORT)) begin
                last_grant_r <= up_sel_r;
            end else begin
                last_grant_r <= last_grant_r;
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            up_start_r <= 1'b0;
            up_rst_r   <= 1'b0;
            ack_lo_r   <= 1'b0;
            ack_hi_r   <= 1'b0;
            err_r      <= 1'b0;
            busy_r     <= 1'b0;
            up_sel_r   <= 1'b0;
            up_dlt_r   <= 17'h00000;
        end else begin
            up_start_r <= (state_next_s == ST_RUN);
            busy_r     <= (state_next_s != ST_IDLE);
            ack_lo_r   <= ((state_next_s == ST_DONE) || (state_next_s == ST_ABORT)) && !up_sel_r;
            ack_hi_r   <= ((state_next_s == ST_DONE) || (state_next_s == ST_ABORT)) && up_sel_r;
            err_r      <= (state_next_s == ST_ABORT);
            up_rst_r   <= (state_next_s == ST_ABORT);
            if (grant_s) begin
                up_sel_r <= grant_band_s;
                up_dlt_r <= grant_band_s ? dlt_hi : dlt_lo;
            end else begin
                up_sel_r <= up_sel_r;
                up_dlt_r <= up_dlt_r;
            end
        end
    end

    assign ack_lo   = ack_lo_r;
    assign ack_hi   = ack_hi_r;
    assign err      = err_r;
    assign busy     = busy_r;
    assign up_start = up_start_r;
    assign up_dlt   = up_dlt_r;
    assign up_sel   = up_sel_r;
    assign up_rst   = up_rst_r;

endmodule

// File: tb/tb_upzero_sched.sv
// Self-checking bench for upzero_sched: an engine model with programmable latency
// plus a transaction-level reference model of grant order, run length and abort.
module tb_upzero_sched;

    localparam int TO = 24;

    logic        ap_clk = 1'b0;
    logic        ap_rst, req_lo, req_hi, up_ready, up_done;
    logic [16:0] dlt_lo, dlt_hi;
    logic        ack_lo, ack_hi, err, busy, up_start, up_sel, up_rst;
    logic [16:0] up_dlt;

    upzero_sched #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_lo(req_lo), .dlt_lo(dlt_lo), .req_hi(req_hi), .dlt_hi(dlt_hi),
        .ack_lo(ack_lo), .ack_hi(ack_hi), .err(err), .busy(busy),
        .up_start(up_start), .up_dlt(up_dlt), .up_sel(up_sel),
        .up_ready(up_ready), .up_done(up_done), .up_rst(up_rst)
    );

    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // engine model: completes on the eng_lat-th cycle of up_start (1-based)
    int eng_lat  = 1;
    bit eng_spur = 1'b0;
    int run_seen = 0;

    initial begin
        up_ready = 1'b0;
        up_done  = 1'b0;
        forever begin
            @(negedge ap_clk);
            if (up_start === 1'b1) run_seen++;
            else run_seen = 0;
            up_ready = (up_start === 1'b1) && (run_seen == eng_lat);
            up_done  = eng_spur ? 1'b1 : up_ready;
        end
    end

    // reference model state
    bit model_last = 1'b1;

    function automatic bit pick(input bit lo, input bit hi);
        if (lo && hi) return ~model_last;
        return hi;
    endfunction

    // {ok, wait, sel, dlt, runlen, ack_lo, ack_hi, err, up_rst, tail[4:0], stable}
    function automatic logic [40:0] expect_vec(input bit band, input logic [16:0] dlt, input int lat);
        int rl;
        bit ab;
        rl = (lat < TO) ? lat : TO;
        ab = (lat > TO);
        return {1'b1, 4'd1, band, dlt, 8'(rl), ~band, band, ab, ab, 5'b00000, 1'b1};
    endfunction

    bit          obs_ok, obs_sel, obs_stable, obs_ack_lo, obs_ack_hi, obs_err, obs_rst;
    logic [16:0] obs_dlt;
    logic [4:0]  obs_tail;
    int          obs_runlen, obs_wait;

    function automatic logic [40:0] observed();
        return {obs_ok, 4'(obs_wait), obs_sel, obs_dlt, 8'(obs_runlen),
                obs_ack_lo, obs_ack_hi, obs_err, obs_rst, obs_tail, obs_stable};
    endfunction

    // drop_mode: 0 = acked band drops req, 1 = keep both, 2 = drop both
    task automatic watch_update(input int drop_mode);
        int n;
        n = 0; obs_ok = 1'b0; obs_runlen = 0; obs_stable = 1'b1; obs_wait = 0;
        obs_sel = 1'b0; obs_dlt = 17'h00000; obs_tail = 5'h1f;
        obs_ack_lo = 1'b0; obs_ack_hi = 1'b0; obs_err = 1'b0; obs_rst = 1'b0;
        while (up_start !== 1'b1 && n < 10) begin @(negedge ap_clk); n++; end
        obs_wait = n;
        if (up_start !== 1'b1) return;
        obs_sel = up_sel;
        obs_dlt = up_dlt;
        n = 0;
        while (up_start === 1'b1 && n < TO + 8) begin
            obs_runlen++;
            if (up_sel !== obs_sel || up_dlt !== obs_dlt || busy !== 1'b1 ||
                (ack_lo | ack_hi | err | up_rst) !== 1'b0) obs_stable = 1'b0;
            @(negedge ap_clk);
            n++;
        end
        if (up_start === 1'b1) return;
        obs_ack_lo = ack_lo; obs_ack_hi = ack_hi; obs_err = err; obs_rst = up_rst;
        if (busy !== 1'b1) obs_stable = 1'b0;
        if (drop_mode == 0) begin
            if (ack_lo) req_lo = 1'b0;
            if (ack_hi) req_hi = 1'b0;
        end else if (drop_mode == 2) begin
            req_lo = 1'b0;
            req_hi = 1'b0;
        end
        @(negedge ap_clk);
        obs_tail = {ack_lo, ack_hi, err, up_rst, busy};
        obs_ok = 1'b1;
    endtask

    task automatic apply_reset();
        ap_rst = 1'b1; req_lo = 1'b0; req_hi = 1'b0;
        eng_spur = 1'b0; eng_lat = 1;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        model_last = 1'b1;
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        apply_reset();
        outs = {up_start, up_rst, ack_lo, ack_hi, err, busy, up_sel, up_dlt};
        n_checks++;
        if (outs !== 23'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", outs, 23'h0);
        end
        repeat (3) @(negedge ap_clk);
        n_checks++;
        if ({busy, up_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_req: busy/up_start got %b want 00", {busy, up_start});
        end
    endtask

    task automatic test_single_lo();
        logic [40:0] exp_v;
        req_lo = 1'b1; dlt_lo = 17'h00123; eng_lat = 20;
        exp_v = expect_vec(pick(1'b1, 1'b0), 17'h00123, 20);
        watch_update(0);
        model_last = 1'b0;
        n_checks++;
        if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL single_lo: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_simultaneous();
        logic [40:0] exp_v;
        bit band;
        apply_reset();
        req_lo = 1'b1; req_hi = 1'b1;
        dlt_lo = 17'($urandom); dlt_hi = 17'($urandom);
        eng_lat = 5;
        for (int k = 0; k < 2; k++) begin
            band = pick(req_lo, req_hi);
            exp_v = expect_vec(band, band ? dlt_hi : dlt_lo, 5);
            watch_update(0);
            model_last = band;
            n_checks++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL tie_from_reset[%0d]: got %h want %h", k, observed(), exp_v);
            end
        end
        req_lo = 1'b1; req_hi = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eng_lat = 3 + k;
            band = pick(1'b1, 1'b1);
            exp_v = expect_vec(band, band ? dlt_hi : dlt_lo, 3 + k);
            watch_update((k == 3) ? 2 : 1);
            model_last = band;
            n_checks++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL alternation[%0d]: got %h want %h", k, observed(), exp_v);
            end
        end
    endtask

    task automatic test_spurious_done();
        logic [40:0] exp_v;
        req_lo = 1'b1; dlt_lo = 17'h1abcd; eng_lat = 10; eng_spur = 1'b1;
        exp_v = expect_vec(pick(1'b1, 1'b0), 17'h1abcd, 10);
        watch_update(0);
        model_last = 1'b0; eng_spur = 1'b0;
        n_checks++;
        if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL spurious_done: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_timeout();
        logic [40:0] exp_v;
        req_hi = 1'b1; dlt_hi = 17'h0f0f0; eng_lat = 1000;
        exp_v = expect_vec(pick(1'b0, 1'b1), 17'h0f0f0, 1000);
        watch_update(0);
        model_last = 1'b1;
        n_checks++;
        if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL timeout_abort: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_race();
        logic [40:0] exp_v;
        req_lo = 1'b1; dlt_lo = 17'h10001; eng_lat = TO;
        exp_v = expect_vec(pick(1'b1, 1'b0), 17'h10001, TO);
        watch_update(0);
        model_last = 1'b0;
        n_checks++;
        if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL race_done_wins: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [40:0] exp_v;
        logic [22:0] outs;
        int n;
        req_lo = 1'b1; dlt_lo = 17'h05a5a; eng_lat = 1000;
        n = 0;
        while (up_start !== 1'b1 && n < 10) begin @(negedge ap_clk); n++; end
        n_checks++;
        if (up_start !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_start: up_start got %b want 1", up_start);
        end
        repeat (4) @(negedge ap_clk);
        ap_rst = 1'b1; req_lo = 1'b0;
        @(negedge ap_clk);
        outs = {up_start, up_rst, ack_lo, ack_hi, err, busy, up_sel, up_dlt};
        n_checks++;
        if (outs !== 23'h0) begin
            n_fail++;
            $display("FAIL mid_run_reset: got %h want %h", outs, 23'h0);
        end
        ap_rst = 1'b0; model_last = 1'b1;
        req_hi = 1'b1; dlt_hi = 17'h13579; eng_lat = 6;
        exp_v = expect_vec(pick(1'b0, 1'b1), 17'h13579, 6);
        watch_update(0);
        model_last = 1'b1;
        n_checks++;
        if (observed() !== exp_v) begin
            n_fail++;
            $display("FAIL reissue_after_reset: got %h want %h", observed(), exp_v);
        end
    endtask

    task automatic test_random();
        logic [40:0] exp_v;
        bit band;
        int lat;
        for (int i = 0; i < 20; i++) begin
            if (i < 14) begin
                if (!req_lo && $urandom_range(0, 1) == 1) begin req_lo = 1'b1; dlt_lo = 17'($urandom); end
                if (!req_hi && $urandom_range(0, 1) == 1) begin req_hi = 1'b1; dlt_hi = 17'($urandom); end
                if (!req_lo && !req_hi) begin req_lo = 1'b1; dlt_lo = 17'($urandom); end
            end
            if (!req_lo && !req_hi) break;
            lat = $urandom_range(1, TO + 3);
            eng_lat = lat;
            eng_spur = ($urandom_range(0, 1) == 1);
            band = pick(req_lo, req_hi);
            exp_v = expect_vec(band, band ? dlt_hi : dlt_lo, lat);
            watch_update(0);
            model_last = band;
            n_checks++;
            if (observed() !== exp_v) begin
                n_fail++;
                $display("FAIL random[%0d] lat=%0d: got %h want %h", i, lat, observed(), exp_v);
            end
        end
        eng_spur = 1'b0;
    endtask

    initial begin
        ap_rst = 1'b1; req_lo = 1'b0; req_hi = 1'b0;
        dlt_lo = 17'h00000; dlt_hi = 17'h00000;
        test_reset();
        test_single_lo();
        test_simultaneous();
        test_spurious_done();
        test_timeout();
        test_race();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upzero_sched.md
Name: upzero_sched

Overview:
- Round-robin scheduler that shares one upzero predictor-update engine between the lower-subband and higher-subband ADPCM encoder paths.
- Accepts per-band update requests and selects one. It latches that band's dlt, drives the engine's ap_start/ap_ready handshake, and selects the band's dlti/bli memory bank through up_sel.
- Returns a one-cycle acknowledge to the requester. A watchdog aborts any update that exceeds a cycle budget.

Parameters:
- TIMEOUT, 64: maximum cycles spent in RUN before the update is aborted. Range 2..(2^CNT_W).
- CNT_W, 7: width of the watchdog counter.

Ports:
- ap_clk  in  1  clock.
- ap_rst  in  1  reset, synchronous, active-high.
- req_lo  in  1  lower-band update request; level; held until ack_lo or err.
- dlt_lo  in  17  lower-band quantised difference; stable while req_lo=1.
- req_hi  in  1  higher-band update request.
- dlt_hi  in  17  higher-band quantised difference.
- ack_lo  out  1  one-cycle pulse: lower-band update finished or aborted.
- ack_hi  out  1  one-cycle pulse: higher-band update finished or aborted.
- err  out  1  one-cycle pulse, coincident with the ack of an aborted update.
- busy  out  1  high in any state other than IDLE.
- up_start  out  1  to the engine's ap_start.
- up_dlt  out  17  to the engine's dlt; registered.
- up_sel  out  1  memory bank select: 0=lo, 1=hi; registered.
- up_ready  in  1  engine ap_ready.
- up_done  in  1  engine ap_done.
- up_rst  out  1  one-cycle engine reset pulse on abort.

Behaviour:
- All outputs are registered.
- Reset (ap_rst=1 at a clock edge, including mid-update):
  - state returns to IDLE.
  - up_start, up_rst, ack_lo, ack_hi, err, busy, up_sel, up_dlt and cnt are all cleared to 0.
  - last_grant is set to hi, so lo wins the first tie.
- States: IDLE, RUN, DONE, ABORT.
- IDLE:
  - req_lo and req_hi are sampled only in this state.
  - Only one request asserted: grant it.
  - Both asserted: grant the band opposite last_grant.
  - On grant, at the clock edge: up_sel <= band, up_dlt <= that band's dlt, cnt <= 0, next state RUN.
  - No request: stay in IDLE.
- RUN:
  - up_start=1 for every RUN cycle; up_dlt and up_sel are held constant; cnt increments each cycle.
  - Completion = up_ready & up_done, sampled in RUN. On completion, next state is DONE.
  - up_done alone is ignored, because the engine also drives ap_done while idle.
  - If cnt == TIMEOUT-1 and completion is not present, next state is ABORT.
  - If completion and timeout occur in the same cycle, completion wins.
  - Dropping req during RUN does not cancel the update.
- DONE:
  - up_start=0, and the granted band's ack pulses for exactly 1 cycle.
  - last_grant <= granted band; next state IDLE.
- ABORT:
  - up_start=0; up_rst=1, err=1 and the granted band's ack=1, all for exactly 1 cycle.
  - last_grant is updated as in DONE; next state IDLE.
- Requester rule: req must be deasserted in the cycle after ack. The scheduler does not re-sample req until IDLE, so there is no double grant.
- Latency:
  - up_start rises 1 cycle after req is sampled in IDLE.
  - ack rises 1 cycle after completion.
  - Minimum request-to-ack time = engine latency + 2 cycles.
  - Back-to-back requests: the next grant happens 1 cycle after ack (IDLE cycle).
- Throughput: at most one update per engine run plus 2 cycles. Strict alternation applies while both bands request.
- up_dlt is a plain copy of the 17-bit input; no sign extension is done here.

Test Plan:
- Single lo: req_lo=1, dlt_lo=17'h00123; engine model asserts up_ready&up_done 20 cycles after up_start -> up_sel=0, up_dlt=17'h00123 throughout RUN; ack_lo pulses 1 cycle after ready; err=0, busy drops next cycle.
- Simultaneous requests: req_lo=req_hi=1 from reset -> lo granted first, then hi granted 1 cycle after ack_lo. Continuous requests from both bands -> grants alternate lo,hi,lo,hi over 4 updates.
- Spurious done: up_done=1, up_ready=0 held during RUN -> no completion; completion occurs only when up_ready=1 arrives.
- Timeout: TIMEOUT=8, engine never ready -> ABORT after 8 RUN cycles; up_rst, err and ack_hi pulse together for 1 cycle; state returns to IDLE.
- Race: up_ready&up_done arrive in the cycle where cnt=TIMEOUT-1 -> DONE path taken, err=0, up_rst=0.
- Reset mid-RUN: ap_rst=1 in the 5th RUN cycle -> next cycle all outputs 0 and state IDLE; a re-issued req_hi is granted normally.
